dircc_stream_packet_arbiter: RTL
================================

// Module: dircc_stream_packet_arbiter
// PURPOSE
//  Shares one Avalon-ST routing port between NUM_REQ processing-node stream_out sources.
//  Arbitration is packet-atomic round-robin: once granted, a source keeps the port until its eop beat is accepted.
//  Sits between the dircc_nios_processing node outputs and the routing-fabric ingress, in the routing clock domain.
//  Beat format matches node streams: 32-bit data, sop/eop, 2-bit empty, ready latency 0.
// PARAMETERS
//  NUM_REQ      4   number of requesting sources (2..16)
//  DATA_WIDTH   32  stream data width
//  EMPTY_WIDTH  2   empty field width
//  CNT_WIDTH    16  width of packet-completed counter (wraps)
// PORTS
//  clk_clk         in   1                     routing clock
//  reset_reset     in   1                     asynchronous active-high reset
//  in_valid        in   NUM_REQ               per-source valid
//  in_data         in   NUM_REQ*DATA_WIDTH    source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_startofpacket in  NUM_REQ               per-source sop
//  in_endofpacket  in   NUM_REQ               per-source eop
//  in_empty        in   NUM_REQ*EMPTY_WIDTH   source i at [i*EMPTY_WIDTH +: EMPTY_WIDTH]
//  in_ready        out  NUM_REQ               per-source ready
//  out_valid       out  1                     merged stream valid
//  out_data        out  DATA_WIDTH            merged data
//  out_startofpacket out 1                    merged sop
//  out_endofpacket out  1                     merged eop
//  out_empty       out  EMPTY_WIDTH           merged empty
//  out_ready       in   1                     downstream ready
//  grant_valid     out  1                     a packet is in flight
//  grant_id        out  $clog2(NUM_REQ)       index of current owner
//  err_orphan      out  1                     1-cycle pulse: non-sop beat discarded in IDLE
//  pkt_count       out  CNT_WIDTH             packets forwarded, wraps to 0
// BEHAVIOUR
//  Reset (async, reset_reset=1): state=IDLE, grant_id=0, grant_valid=0, rr_ptr=NUM_REQ-1 (source 0 wins first),
//   pkt_count=0, err_orphan=0; hence in_ready=0, out_valid=0, out_* data/sop/eop/empty=0.
//  FSM: IDLE, BUSY.
//  IDLE: candidates = in_valid & in_startofpacket. If any, pick first candidate searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ;
//   register grant_id, grant_valid=1, state->BUSY next cycle. No beat transfers in the grant cycle (1-cycle bubble per packet).
//  IDLE orphan rule: sources with in_valid=1 and sop=0 get in_ready=1 in IDLE (beat dropped, not forwarded);
//   err_orphan pulses high the cycle after any such drop. A source chosen this cycle is never also dropped.
//  BUSY: out_* = granted source's fields combinationally; in_ready[grant_id]=out_ready, all other in_ready=0.
//   Transfer = out_valid & out_ready. On transfer with eop=1: state->IDLE, rr_ptr<=grant_id, grant_valid<=0,
//   pkt_count<=pkt_count+1 (mod 2^CNT_WIDTH). grant_id holds its last value in IDLE.
//  Owner sop while BUSY mid-packet (sop after first beat): forwarded unchanged; framing is the source's responsibility.
//  Single-beat packet (sop&eop): BUSY lasts exactly the transfer cycle.
//  out_ready low: BUSY holds indefinitely; no timeout.
//  out_valid may drop mid-packet when owner valid drops; grant is retained.
//  Reset mid-packet: partial packet abandoned; downstream sees no further beats; no recovery beat generated.
//  Latency: sop at input in IDLE -> out_valid with that beat 1 cycle later; data path otherwise combinational.
// STRUCTURE
//  dircc_routing_pkg: state enum {IDLE,BUSY}, default DATA_WIDTH/EMPTY_WIDTH constants, beat field slicing functions.
//  Sub-module dircc_rr_priority_select: combinational round-robin picker (req vector, rr_ptr -> onehot, index, any).
//  Top holds FSM, grant/pointer registers, counter, output mux.
// TESTING
//  1) Reset, src0 sends 3-beat pkt D0..D2, out_ready=1 -> grant_id=0 after 1 cycle, out beats D0..D2 contiguous, pkt_count=1.
//  2) src0..src3 each hold a 2-beat pkt at once -> order 0,1,2,3; each preceded by 1 bubble; pkt_count=4; no interleave.
//  3) src1 pkt in flight, out_ready toggled 1,0,0,1 -> beats held stable while ready=0, in_ready[1] mirrors out_ready, others 0.
//  4) IDLE, src2 valid with sop=0 data 0xDEAD -> in_ready[2]=1 one cycle, err_orphan pulse next cycle, out_valid stays 0.
//  5) Single-beat pkts back-to-back from src3 only -> one pkt per 2 cycles, sop=eop=1, empty passed (e.g. 2'd3).
//  6) Assert reset_reset mid-packet of src0, then src1 sends -> all outputs 0 during reset, src1 granted first after? no: rr_ptr reset, src0 priority if requesting, else src1.

Source files
------------

// File: rtl/dircc_routing_pkg.sv
// Shared types and helpers for the routing-side stream blocks.
package dircc_routing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_EMPTY_WIDTH = 2;

  // Bit offset of source idx's field inside a flattened per-source bus.
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dircc_rr_priority_select.sv
// Combinational round-robin picker: the search starts one past ptr_i and wraps.
module dircc_rr_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walk ptr+1, ptr+2, ... mod N and keep the first requester found.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
        any_o                             = 1'b1;
        idx_o                             = IDX_W'((int'(ptr_i) + k) % N);
        onehot_o[(int'(ptr_i) + k) % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dircc_stream_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_REQ Avalon-ST sources onto one port.
module dircc_stream_packet_arbiter
  import dircc_routing_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int EMPTY_WIDTH = DEF_EMPTY_WIDTH,
  parameter int CNT_WIDTH   = 16,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  input  logic [NUM_REQ-1:0]             in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_REQ-1:0]             in_startofpacket,
  input  logic [NUM_REQ-1:0]             in_endofpacket,
  input  logic [NUM_REQ*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_REQ-1:0]             in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_startofpacket,
  output logic                           out_endofpacket,
  output logic [EMPTY_WIDTH-1:0]         out_empty,
  input  logic                           out_ready,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_id,
  output logic                           err_orphan,
  output logic [CNT_WIDTH-1:0]           pkt_count
);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic                 grant_valid_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [CNT_WIDTH-1:0] pkt_count_q;
  logic [CNT_WIDTH-1:0] pkt_count_d;
  logic                 err_orphan_q;

  logic [NUM_REQ-1:0]   candidates;
  logic [NUM_REQ-1:0]   orphans;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 xfer_eop;

  assign candidates  = in_valid & in_startofpacket;
  assign orphans     = (state_q == IDLE) ? (in_valid & ~in_startofpacket & ~pick_onehot) : '0;
  assign xfer_eop    = (state_q == BUSY) && out_valid && out_ready && out_endofpacket;
  assign pkt_count_d = pkt_count_q + CNT_WIDTH'(1);

  dircc_rr_priority_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (candidates),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Output mux and ready steering; IDLE drains non-sop beats, and nothing is accepted while reset is held.
  always_comb begin
    out_valid         = 1'b0;
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    in_ready          = '0;
    if (state_q == BUSY) begin
      out_valid            = in_valid[grant_id_q];
      out_data             = in_data[field_lsb(int'(grant_id_q), DATA_WIDTH) +: DATA_WIDTH];
      out_startofpacket    = in_startofpacket[grant_id_q];
      out_endofpacket      = in_endofpacket[grant_id_q];
      out_empty            = in_empty[field_lsb(int'(grant_id_q), EMPTY_WIDTH) +: EMPTY_WIDTH];
      in_ready[grant_id_q] = out_ready;
    end else if (!reset_reset) begin
      in_ready = orphans;
    end
  end

  // Arbitration FSM with grant, pointer, counter and orphan-flag registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      pkt_count_q   <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      err_orphan_q <= 1'b0;
      case (state_q)
        IDLE: begin
          err_orphan_q <= |orphans;
          if (pick_any) begin
            state_q       <= BUSY;
            grant_id_q    <= pick_idx;
            grant_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (xfer_eop) begin
            state_q       <= IDLE;
            rr_ptr_q      <= grant_id_q;
            grant_valid_q <= 1'b0;
            pkt_count_q   <= pkt_count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign err_orphan  = err_orphan_q;
  assign pkt_count   = pkt_count_q;

endmodule
